// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one ALU datapath (add/and/or/sub) between two requesters.
//   It grants one request at a time, alternating round-robin when both
//   requesters are valid. It captures the operands, computes the result in
//   the next cycle, and holds the result until the consumer accepts it.
//
// Ports
//   clk, reset_n        rising-edge clock, async active-low reset
//   req_valid/ready[2]  per-requester handshake; ready is one-hot or zero
//   req_a/b             operands, requester i at [i*WIDTH +: WIDTH]
//   req_ctrl            ALU control code, requester i at [i*CTRL_W +: CTRL_W]
//   rsp_valid/ready     result handshake
//   rsp_id              requester that owns the held result
//   rsp_result/zero     registered ALU result and its zero flag
//   rsp_illegal         captured control code was not add/and/or/sub
module alu_share_arbiter #(
    parameter int WIDTH  = 64,
    parameter int CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*WIDTH-1:0]    req_a,
    input  logic [2*WIDTH-1:0]    req_b,
    input  logic [2*CTRL_W-1:0]   req_ctrl,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_illegal
);

    localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(4'b0110);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    typedef struct packed {
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic [CTRL_W-1:0] ctrl;
        logic              id;
    } op_t;

    state_t           state, state_nxt;
    logic             rr_ptr;
    op_t              cap;
    logic             gnt;
    logic             any_req;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;

    // On a tie the round-robin pointer decides; otherwise the lone valid requester wins.
    always_comb begin
        any_req = |req_valid;
        gnt     = (&req_valid) ? rr_ptr : req_valid[1];
    end

    // req_ready depends on reset_n so that it reads 0 while reset is held,
    // even if requesters are already presenting work.
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        case (state)
            IDLE: begin
                if (any_req && reset_n) begin
                    req_ready = gnt ? 2'b10 : 2'b01;
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = HOLD;
            HOLD:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == HOLD);

    // The ALU works only on the captured operands, so a requester that drops
    // valid after its grant cannot disturb the operation in flight.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (cap.ctrl)
            OP_ADD:  alu_res = cap.a + cap.b;
            OP_AND:  alu_res = cap.a & cap.b;
            OP_OR:   alu_res = cap.a | cap.b;
            OP_SUB:  alu_res = cap.a - cap.b;
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= 1'b0;
            cap    <= '0;
        end else if (state == IDLE && any_req) begin
            rr_ptr   <= ~gnt;
            cap.a    <= gnt ? req_a[2*WIDTH-1:WIDTH]     : req_a[WIDTH-1:0];
            cap.b    <= gnt ? req_b[2*WIDTH-1:WIDTH]     : req_b[WIDTH-1:0];
            cap.ctrl <= gnt ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];
            cap.id   <= gnt;
        end
    end

    // The zero flag comes from this cycle's ALU output, so it always matches rsp_result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else if (state == EXEC) begin
            rsp_id      <= cap.id;
            rsp_result  <= alu_res;
            rsp_zero    <= (alu_res == '0);
            rsp_illegal <= alu_ill;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [7:0]   req_ctrl;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [63:0]  rsp_result;
    logic         rsp_zero;
    logic         rsp_illegal;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(64), .CTRL_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  c;
    } op_t;

    int errors = 0;
    int checks = 0;

    // per-requester pending work and the operation currently presented
    op_t q0[$];
    op_t q1[$];
    op_t slot[2];
    bit  slot_v[2];

    // reference model: one op in flight, visible from the cycle after its compute cycle
    bit          m_busy;
    int          m_age;
    bit          m_rr;
    bit          m_id;
    logic [63:0] m_res;
    bit          m_zero;
    bit          m_ill;
    int          obs_ids[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
        op_t o;
        o.a = a; o.b = b; o.c = c;
        return o;
    endfunction

    task automatic ref_alu(input op_t o, output logic [63:0] r, output bit ill);
        ill = 0;
        case (o.c)
            4'd2:    r = o.a + o.b;
            4'd0:    r = o.a & o.b;
            4'd1:    r = o.a | o.b;
            4'd6:    r = o.a - o.b;
            default: begin r = 64'd0; ill = 1; end
        endcase
    endtask

    task automatic step(input bit rdy);
        bit g_any, g, exp_rv;
        @(negedge clk);
        if (!slot_v[0] && q0.size() > 0) begin slot[0] = q0.pop_front(); slot_v[0] = 1; end
        if (!slot_v[1] && q1.size() > 0) begin slot[1] = q1.pop_front(); slot_v[1] = 1; end
        req_valid = {slot_v[1], slot_v[0]};
        req_a     = {slot[1].a, slot[0].a};
        req_b     = {slot[1].b, slot[0].b};
        req_ctrl  = {slot[1].c, slot[0].c};
        rsp_ready = rdy;
        #1;
        exp_rv = m_busy && (m_age >= 1);
        g_any  = !m_busy && (slot_v[0] || slot_v[1]);
        g      = (slot_v[0] && slot_v[1]) ? m_rr : slot_v[1];
        chk("req_ready", 64'(req_ready), g_any ? (g ? 64'd2 : 64'd1) : 64'd0);
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            chk("rsp_result",  rsp_result,          m_res);
            chk("rsp_zero",    64'(rsp_zero),    64'(m_zero));
            chk("rsp_illegal", 64'(rsp_illegal), 64'(m_ill));
            chk("rsp_id",      64'(rsp_id),      64'(m_id));
        end
        if (g_any) begin
            m_busy = 1; m_age = 0; m_id = g; m_rr = !g;
            ref_alu(slot[g], m_res, m_ill);
            m_zero = (m_res == 64'd0);
            slot_v[g] = 0;
        end else if (m_busy) begin
            if (exp_rv && rdy) begin
                m_busy = 0;
                if (rsp_valid) obs_ids.push_back(int'(rsp_id));
            end else begin
                m_age++;
            end
        end
    endtask

    function automatic bit all_done();
        return q0.size() == 0 && q1.size() == 0 && !slot_v[0] && !slot_v[1] && !m_busy;
    endfunction

    task automatic settle(input int budget, output int used);
        used = 0;
        while (!all_done() && used < budget) begin
            step(1'b1);
            used++;
        end
        if (!all_done()) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    // Assert reset now (asynchronously), check outputs at once, release at a negedge
    // with req_valid low so no grant can slip in before the next checked cycle.
    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("rst_req_ready",   64'(req_ready),   64'd0);
        chk("rst_rsp_valid",   64'(rsp_valid),   64'd0);
        chk("rst_rsp_result",  rsp_result,       64'd0);
        chk("rst_rsp_zero",    64'(rsp_zero),    64'd0);
        chk("rst_rsp_illegal", 64'(rsp_illegal), 64'd0);
        chk("rst_rsp_id",      64'(rsp_id),      64'd0);
        m_busy = 0; m_age = 0; m_rr = 0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        reset_n   = 1'b1;
    endtask

    initial begin
        int used;
        reset_n = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0; rsp_ready = 1'b0;
        slot_v[0] = 0; slot_v[1] = 0;
        slot[0] = mk(0, 0, 0); slot[1] = mk(0, 0, 0);
        #2;
        do_reset();

        // lone add on requester 0
        q0.push_back(mk(64'd5, 64'd7, 4'b0010));
        settle(20, used);
        chk("add_latency", 64'(used), 64'd3);

        // requester 1 subtracts: equal operands and wraparound
        q1.push_back(mk(64'd9, 64'd9, 4'b0110));
        q1.push_back(mk(64'd0, 64'd1, 4'b0110));
        settle(20, used);

        // both held from reset: strict alternation, 3-cycle throughput
        @(negedge clk); do_reset();
        obs_ids.delete();
        q0.push_back(mk(64'hF0, 64'h3C, 4'b0000));
        q1.push_back(mk(64'hF0, 64'h0F, 4'b0001));
        q0.push_back(mk(64'h1234, 64'h1, 4'b0010));
        q1.push_back(mk(64'h10, 64'h20, 4'b0110));
        settle(40, used);
        chk("rr_cycles", 64'(used), 64'd12);
        chk("rr_count", 64'(obs_ids.size()), 64'd4);
        for (int i = 0; i < obs_ids.size() && i < 4; i++)
            chk("rr_order", 64'(obs_ids[i]), 64'(i % 2));

        // backpressure: hold the response, the other requester must wait
        q0.push_back(mk(64'hAA, 64'h55, 4'b0001));
        q1.push_back(mk(64'h3, 64'h2, 4'b0010));
        for (int i = 0; i < 8; i++) step(1'b0);
        settle(20, used);

        // unsupported code, then a legal op clears the flag
        q0.push_back(mk(64'd3, 64'd4, 4'b1111));
        q0.push_back(mk(64'd3, 64'd4, 4'b0010));
        settle(20, used);

        // reset while holding: no response, pointer back to requester 0
        q1.push_back(mk(64'd8, 64'd8, 4'b0010));
        for (int i = 0; i < 3; i++) step(1'b0);
        chk("hold_reached", 64'(rsp_valid), 64'd1);
        do_reset();
        obs_ids.delete();
        q0.push_back(mk(64'd1, 64'd1, 4'b0010));
        q1.push_back(mk(64'd2, 64'd2, 4'b0010));
        settle(20, used);
        chk("post_rst_count", 64'(obs_ids.size()), 64'd2);
        if (obs_ids.size() > 0) chk("post_rst_first", 64'(obs_ids[0]), 64'd0);

        // random traffic and backpressure
        for (int i = 0; i < 400; i++) begin
            int    pick;
            op_t   o;
            pick = $urandom_range(0, 4);
            o = mk({$urandom, $urandom}, {$urandom, $urandom},
                   pick == 0 ? 4'b0000 : pick == 1 ? 4'b0001 : pick == 2 ? 4'b0010 :
                   pick == 3 ? 4'b0110 : 4'($urandom));
            if ($urandom_range(0, 9) == 0) o.b = o.a;
            if ($urandom_range(0, 3) == 0 && q0.size() < 3) q0.push_back(o);
            else if ($urandom_range(0, 3) == 0 && q1.size() < 3) q1.push_back(o);
            step(1'($urandom_range(0, 2) != 0));
        end
        settle(200, used);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
